// File: rtl/display_scan_ctrl_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment scanner.
package disp_pkg;

    // Scan sequencer states: dark and idle, inter-digit gap, digit lit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    // Decoder code that drives every segment off.
    localparam logic [3:0] BCD_OFF = 4'hF;

    // Widest digit bus the leading-zero helper handles.
    localparam int MAX_DIGITS = 16;

    // Bit i is set when digit i and every digit above it (up to num_digits-1) is zero.
    // Digit 0 is never flagged, so an all-zero value still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] shadow,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zeros_above;
        mask        = '0;
        zeros_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < num_digits) begin
                zeros_above = zeros_above & (shadow[4*i +: 4] == 4'd0);
                if (i != 0) begin
                    mask[i] = zeros_above;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_timer.sv
// Loadable down-counter that times the BLANK and ON phases of the scanner.
// done is high while the count sits at zero, i.e. in the last cycle of a phase
// when the phase was loaded with (length - 1).
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] period,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = period;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: sequences digit anodes with a
// blanking gap between digits, shows a per-frame snapshot of the digit bus and
// optionally blanks leading zeros. All outputs are registered.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          lz_blank_en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    output logic [3:0]                    digit_bcd,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [$clog2(NUM_DIGITS)-1:0] cur_idx,
    output logic                          frame_tick
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXP = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int TW   = $clog2(MAXP + 1);

    localparam bit            HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam logic [TW-1:0] ON_LOAD    = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    // Period loaded whenever a digit is about to start (gap first if there is one).
    localparam logic [TW-1:0] NEXT_LOAD  = HAS_BLANK ? BLANK_LOAD : ON_LOAD;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_DIGITS - 1);

    scan_state_t             state_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [IW-1:0]           cur_idx_q;
    logic [NUM_DIGITS-1:0]   anode_q;
    logic [3:0]              bcd_q;
    logic                    tick_q;

    logic                    tmr_load;
    logic [TW-1:0]           tmr_period;
    logic                    tmr_done;

    logic                    at_wrap;
    logic [IW-1:0]           next_idx;
    logic [4*NUM_DIGITS-1:0] disp_shadow;
    logic [IW-1:0]           disp_idx;
    logic [4*MAX_DIGITS-1:0] shadow_pad;
    logic [MAX_DIGITS-1:0]   lz_bits;
    logic [3:0]              raw_digit;
    logic [3:0]              disp_code;
    logic [NUM_DIGITS-1:0]   disp_anode;

    scan_timer #(
        .W (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .period (tmr_period),
        .done   (tmr_done)
    );

    // Pick which snapshot and index the registered outputs will show after this edge;
    // on a wrap or a start the fresh digits_in is used so the new frame shows at once.
    always_comb begin
        at_wrap     = (cur_idx_q == LAST_IDX);
        next_idx    = at_wrap ? '0 : cur_idx_q + IW'(1);
        disp_shadow = shadow_q;
        disp_idx    = cur_idx_q;
        if (state_q == IDLE) begin
            disp_shadow = digits_in;
            disp_idx    = '0;
        end else if (state_q == ON && tmr_done) begin
            disp_idx = next_idx;
            if (at_wrap) begin
                disp_shadow = digits_in;
            end
        end
    end

    // Shown code and anode pattern for the selected digit (out-of-range and leading zeros go dark).
    always_comb begin
        shadow_pad                   = '0;
        shadow_pad[4*NUM_DIGITS-1:0] = disp_shadow;
        lz_bits                      = lz_mask(shadow_pad, NUM_DIGITS);
        raw_digit                    = disp_shadow[4*disp_idx +: 4];
        if (raw_digit > 4'd9) begin
            disp_code = BCD_OFF;
        end else if (lz_blank_en && lz_bits[disp_idx]) begin
            disp_code = BCD_OFF;
        end else begin
            disp_code = raw_digit;
        end
        disp_anode = ANODE_OFF ^ (NUM_DIGITS'(1) << disp_idx);
    end

    // Timer reload on every phase entry; held cleared while disabled.
    always_comb begin
        tmr_load   = 1'b0;
        tmr_period = '0;
        if (!enable) begin
            tmr_load   = 1'b1;
            tmr_period = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_load   = 1'b1;
                    tmr_period = NEXT_LOAD;
                end
                BLANK: begin
                    tmr_load   = tmr_done;
                    tmr_period = ON_LOAD;
                end
                ON: begin
                    tmr_load   = tmr_done;
                    tmr_period = NEXT_LOAD;
                end
                default: begin
                    tmr_load   = 1'b1;
                    tmr_period = '0;
                end
            endcase
        end
    end

    // Scan sequencer with registered anode, code, index and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= {NUM_DIGITS{BCD_OFF}};
            cur_idx_q <= '0;
            anode_q   <= ANODE_OFF;
            bcd_q     <= BCD_OFF;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (!enable) begin
                // Disable wins over everything, including a coincident wrap.
                state_q   <= IDLE;
                cur_idx_q <= '0;
                anode_q   <= ANODE_OFF;
                bcd_q     <= BCD_OFF;
            end else begin
                case (state_q)
                    IDLE: begin
                        shadow_q  <= digits_in;
                        cur_idx_q <= '0;
                        if (HAS_BLANK) begin
                            state_q <= BLANK;
                            anode_q <= ANODE_OFF;
                            bcd_q   <= BCD_OFF;
                        end else begin
                            state_q <= ON;
                            anode_q <= disp_anode;
                            bcd_q   <= disp_code;
                        end
                    end
                    BLANK: begin
                        if (tmr_done) begin
                            state_q <= ON;
                            anode_q <= disp_anode;
                            bcd_q   <= disp_code;
                        end else begin
                            anode_q <= ANODE_OFF;
                            bcd_q   <= BCD_OFF;
                        end
                    end
                    ON: begin
                        if (tmr_done) begin
                            cur_idx_q <= next_idx;
                            if (at_wrap) begin
                                tick_q   <= 1'b1;
                                shadow_q <= digits_in;
                            end
                            if (HAS_BLANK) begin
                                state_q <= BLANK;
                                anode_q <= ANODE_OFF;
                                bcd_q   <= BCD_OFF;
                            end else begin
                                anode_q <= disp_anode;
                                bcd_q   <= disp_code;
                            end
                        end else begin
                            // Refresh every ON cycle so lz_blank_en acts live.
                            anode_q <= disp_anode;
                            bcd_q   <= disp_code;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        cur_idx_q <= '0;
                        anode_q   <= ANODE_OFF;
                        bcd_q     <= BCD_OFF;
                    end
                endcase
            end
        end
    end

    assign digit_bcd  = bcd_q;
    assign anode      = anode_q;
    assign cur_idx    = cur_idx_q;
    assign frame_tick = tick_q;

endmodule
